// File: rtl/chips_if_pkg.sv
// Shared types and constants for the streaming Dawson chips bridge.
package chips_if_pkg;

    typedef enum logic [1:0] {
        RESET  = 2'd0,
        IDLE   = 2'd1,
        TX     = 2'd2,
        WAIT_Z = 2'd3
    } state_t;

    localparam int WIDTH_SP = 32;
    localparam int WIDTH_DP = 64;

endpackage

// File: rtl/chips_fifo.sv
// Small synchronous FIFO with occupancy count and combinational head read.
module chips_fifo #(
    parameter int DW    = 64,
    parameter int DEPTH = 4
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     push,
    input  logic [DW-1:0]            push_data,
    input  logic                     pop,
    output logic [DW-1:0]            head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    // A full FIFO refuses a push even when a pop happens on the same edge.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    assign full  = (count == FULL_COUNT);
    assign empty = (count == '0);
    assign head  = mem[rd_ptr];

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/dawson_stream_if.sv
// Streaming valid/ready front end for one Dawson FPU unit: operand FIFO,
// chips strobe/ack sequencer, and result FIFO with user backpressure.
module dawson_stream_if
    import chips_if_pkg::*;
#(
    parameter int WIDTH        = 32,
    parameter int DEPTH        = 4,
    parameter int NUM_OPERANDS = 2
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [WIDTH-1:0]        in_a,
    input  logic [WIDTH-1:0]        in_b,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [WIDTH-1:0]        out_z,
    output logic                    busy,
    output logic                    clk,
    output logic                    rst,
    output logic [WIDTH-1:0]        input_a,
    output logic [WIDTH-1:0]        input_b,
    output logic                    input_a_stb,
    output logic                    input_b_stb,
    input  logic                    input_a_ack,
    input  logic                    input_b_ack,
    input  logic [WIDTH-1:0]        output_z,
    input  logic                    output_z_stb,
    output logic                    output_z_ack,
    output logic [1:0]              dbg_state,
    output logic [$clog2(DEPTH):0]  dbg_op_count,
    output logic [$clog2(DEPTH):0]  dbg_res_count
);

    // Handshakes: a transfer happens on a rising clock edge where the
    // producer's valid/stb and the consumer's ready/ack are both high.

    state_t             state;
    logic [WIDTH-1:0]   opa;
    logic [WIDTH-1:0]   opb;
    logic               a_done;
    logic               b_done;
    logic               a_done_nxt;
    logic               b_done_nxt;

    logic [2*WIDTH-1:0] op_head;
    logic               op_full;
    logic               op_empty;
    logic               op_push;
    logic               op_pop;

    logic [WIDTH-1:0]   res_head;
    logic               res_full;
    logic               res_empty;
    logic               res_pop;

    assign op_push = in_valid && in_ready;
    assign op_pop  = (state == IDLE) && !op_empty;
    assign res_pop = out_valid && out_ready;

    chips_fifo #(
        .DW    (2 * WIDTH),
        .DEPTH (DEPTH)
    ) u_op_fifo (
        .clock     (clock),
        .reset_n   (reset_n),
        .push      (op_push),
        .push_data ({in_a, (NUM_OPERANDS == 2) ? in_b : {WIDTH{1'b0}}}),
        .pop       (op_pop),
        .head      (op_head),
        .full      (op_full),
        .empty     (op_empty),
        .count     (dbg_op_count)
    );

    chips_fifo #(
        .DW    (WIDTH),
        .DEPTH (DEPTH)
    ) u_res_fifo (
        .clock     (clock),
        .reset_n   (reset_n),
        .push      (output_z_ack),
        .push_data (output_z),
        .pop       (res_pop),
        .head      (res_head),
        .full      (res_full),
        .empty     (res_empty),
        .count     (dbg_res_count)
    );

    assign a_done_nxt = a_done || (input_a_stb && input_a_ack);
    assign b_done_nxt = b_done || (input_b_stb && input_b_ack);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state  <= RESET;
            opa    <= '0;
            opb    <= '0;
            a_done <= 1'b0;
            b_done <= 1'b0;
        end else begin
            case (state)
                RESET: state <= IDLE;
                IDLE: begin
                    if (op_pop) begin
                        opa    <= op_head[2*WIDTH-1:WIDTH];
                        opb    <= op_head[WIDTH-1:0];
                        a_done <= 1'b0;
                        // Unary units never see a B strobe.
                        b_done <= (NUM_OPERANDS == 1);
                        state  <= TX;
                    end
                end
                TX: begin
                    a_done <= a_done_nxt;
                    b_done <= b_done_nxt;
                    if (a_done_nxt && b_done_nxt) state <= WAIT_Z;
                end
                WAIT_Z: begin
                    if (output_z_ack) state <= IDLE;
                end
                default: state <= RESET;
            endcase
        end
    end

    assign clk          = clock;
    assign rst          = (state == RESET);
    assign in_ready     = !op_full && (state != RESET);
    assign input_a_stb  = (state == TX) && !a_done;
    assign input_b_stb  = (state == TX) && !b_done && (NUM_OPERANDS == 2);
    assign input_a      = input_a_stb ? opa : '0;
    assign input_b      = input_b_stb ? opb : '0;
    // A full result FIFO stalls the unit rather than passing results through.
    assign output_z_ack = (state == WAIT_Z) && output_z_stb && !res_full;
    assign out_valid    = !res_empty;
    assign out_z        = out_valid ? res_head : '0;
    assign busy         = ((state != IDLE) && (state != RESET)) || !op_empty || !res_empty;
    assign dbg_state    = state;

endmodule

// File: tb/tb_dawson_stream_if.sv
// Bench for dawson_stream_if: single-precision binary instance with a
// configurable stub adder, plus a double-precision unary int_to_float instance.
module tb_dawson_stream_if;

    localparam int DEPTH = 4;
    localparam logic [1:0] S_RESET  = 2'd0;
    localparam logic [1:0] S_IDLE   = 2'd1;
    localparam logic [1:0] S_TX     = 2'd2;
    localparam logic [1:0] S_WAIT_Z = 2'd3;

    logic        clock;
    logic        reset_n;

    // single-precision binary instance
    logic        in_valid, in_ready, out_valid, out_ready, busy, clk, rst;
    logic [31:0] in_a, in_b, out_z, input_a, input_b, output_z;
    logic        input_a_stb, input_b_stb, input_a_ack, input_b_ack;
    logic        output_z_stb, output_z_ack;
    logic [1:0]  dbg_state;
    logic [2:0]  dbg_op_count, dbg_res_count;

    // double-precision unary instance
    logic        in_valid_dp, in_ready_dp, out_valid_dp, out_ready_dp, busy_dp, clk_dp, rst_dp;
    logic [63:0] in_a_dp, in_b_dp, out_z_dp, input_a_dp, input_b_dp, output_z_dp;
    logic        input_a_stb_dp, input_b_stb_dp, input_a_ack_dp, input_b_ack_dp;
    logic        output_z_stb_dp, output_z_ack_dp;
    logic [1:0]  dbg_state_dp;
    logic [2:0]  dbg_op_count_dp, dbg_res_count_dp;

    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] exp_q[$];
    logic [63:0] exp_q_dp[$];

    // stub / monitor state
    int a_dly = 0, b_dly = 0, z_lat = 0;
    int a_cnt, b_cnt, z_cnt;
    logic got_a, got_b, a_take, b_take, z_take, a_prev;
    logic [31:0] a_val, b_val;
    int n_a_hs = 0, n_b_hs = 0, a_drop = 0, b_restrobe = 0, z_stall = 0, ack_when_full = 0;
    logic got_a_dp, a_take_dp, z_take_dp;
    logic [63:0] a_val_dp;
    int b_stb_dp_seen = 0;
    int rd_mode = 1, rd_mode_dp = 0;
    int n_out = 0, n_out_dp = 0;
    logic saw_backpressure;
    int base_out, base_a, base_b, i_guard;

    dawson_stream_if #(.WIDTH(32), .DEPTH(DEPTH), .NUM_OPERANDS(2)) u_dut (
        .clock(clock), .reset_n(reset_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
        .out_valid(out_valid), .out_ready(out_ready), .out_z(out_z), .busy(busy),
        .clk(clk), .rst(rst), .input_a(input_a), .input_b(input_b),
        .input_a_stb(input_a_stb), .input_b_stb(input_b_stb),
        .input_a_ack(input_a_ack), .input_b_ack(input_b_ack),
        .output_z(output_z), .output_z_stb(output_z_stb), .output_z_ack(output_z_ack),
        .dbg_state(dbg_state), .dbg_op_count(dbg_op_count), .dbg_res_count(dbg_res_count)
    );

    dawson_stream_if #(.WIDTH(64), .DEPTH(DEPTH), .NUM_OPERANDS(1)) u_dut_dp (
        .clock(clock), .reset_n(reset_n),
        .in_valid(in_valid_dp), .in_ready(in_ready_dp), .in_a(in_a_dp), .in_b(in_b_dp),
        .out_valid(out_valid_dp), .out_ready(out_ready_dp), .out_z(out_z_dp), .busy(busy_dp),
        .clk(clk_dp), .rst(rst_dp), .input_a(input_a_dp), .input_b(input_b_dp),
        .input_a_stb(input_a_stb_dp), .input_b_stb(input_b_stb_dp),
        .input_a_ack(input_a_ack_dp), .input_b_ack(input_b_ack_dp),
        .output_z(output_z_dp), .output_z_stb(output_z_stb_dp), .output_z_ack(output_z_ack_dp),
        .dbg_state(dbg_state_dp), .dbg_op_count(dbg_op_count_dp), .dbg_res_count(dbg_res_count_dp)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // ---------------- float helpers ----------------
    function automatic real sp_to_real(input logic [31:0] s);
        logic [63:0] d;
        int e;
        if (s[30:0] == 31'd0) return 0.0;
        e = int'(s[30:23]) - 127 + 1023;
        d = {s[31], e[10:0], s[22:0], 29'd0};
        return $bitstoreal(d);
    endfunction

    function automatic logic [31:0] real_to_sp(input real r);
        logic [63:0] d;
        int e;
        if (r == 0.0) return 32'd0;
        d = $realtobits(r);
        e = int'(d[62:52]) - 1023 + 127;
        return {d[63], e[7:0], d[51:29]};
    endfunction

    function automatic logic [31:0] sp_add(input logic [31:0] a, input logic [31:0] b);
        return real_to_sp(sp_to_real(a) + sp_to_real(b));
    endfunction

    function automatic logic [31:0] sp_of_int(input int v);
        return real_to_sp(real'(v));
    endfunction

    // ---------------- checker ----------------
    task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic tick;
        @(negedge clock);
        #1;
    endtask

    // ---------------- driver tasks ----------------
    task automatic send32(input logic [31:0] a, input logic [31:0] b);
        int guard;
        guard = 0;
        in_valid = 1'b1;
        in_a = a;
        in_b = b;
        #1;
        while (!in_ready && guard < 400) begin
            saw_backpressure = 1'b1;
            tick();
            guard++;
        end
        if (in_ready) exp_q.push_back(sp_add(a, b));
        else check_val("in_ready_timeout", 64'(in_ready), 64'd1);
        @(negedge clock);
        in_valid = 1'b0;
        in_a = '0;
        in_b = '0;
    endtask

    task automatic send64(input int v);
        int guard;
        guard = 0;
        in_valid_dp = 1'b1;
        in_a_dp = 64'(v);
        in_b_dp = 64'hDEAD_BEEF_0000_0001;
        #1;
        while (!in_ready_dp && guard < 400) begin
            tick();
            guard++;
        end
        if (in_ready_dp) exp_q_dp.push_back($realtobits(real'(v)));
        else check_val("in_ready_dp_timeout", 64'(in_ready_dp), 64'd1);
        @(negedge clock);
        in_valid_dp = 1'b0;
        in_a_dp = '0;
        in_b_dp = '0;
    endtask

    task automatic drain32(input string tag);
        rd_mode = 0;
        for (int i = 0; i < 400 && !(exp_q.size() == 0 && !busy); i++) tick();
        check_val(tag, 64'(busy), 64'd0);
    endtask

    // ---------------- stub single-precision adder ----------------
    initial begin
        input_a_ack = 0; input_b_ack = 0; output_z_stb = 0; output_z = '0;
        got_a = 0; got_b = 0; a_take = 0; b_take = 0; z_take = 0; a_prev = 0;
        a_cnt = 0; b_cnt = 0; z_cnt = 0; a_val = '0; b_val = '0;
        forever begin
            @(negedge clock);
            if (!reset_n) begin
                input_a_ack = 0; input_b_ack = 0; output_z_stb = 0; output_z = '0;
                got_a = 0; got_b = 0; a_take = 0; b_take = 0; z_take = 0; a_prev = 0;
                a_cnt = 0; b_cnt = 0; z_cnt = 0;
            end else begin
                if (a_take) begin input_a_ack = 0; got_a = 1; end
                if (b_take) begin input_b_ack = 0; got_b = 1; end
                if (z_take) begin
                    output_z_stb = 0; output_z = '0;
                    got_a = 0; got_b = 0; a_cnt = 0; b_cnt = 0; z_cnt = 0;
                end
                if (input_a_stb && !input_a_ack && !got_a) begin
                    if (a_cnt >= a_dly) begin input_a_ack = 1; a_val = input_a; end
                    else a_cnt++;
                end
                if (input_b_stb && !input_b_ack && !got_b) begin
                    if (b_cnt >= b_dly) begin input_b_ack = 1; b_val = input_b; end
                    else b_cnt++;
                end
                if (got_a && got_b && !output_z_stb) begin
                    if (z_cnt >= z_lat) begin output_z_stb = 1; output_z = sp_add(a_val, b_val); end
                    else z_cnt++;
                end
                #1;
                if (input_b_stb && got_b) b_restrobe++;
                if (a_prev && !input_a_stb && !a_take) a_drop++;
                a_take = input_a_stb && input_a_ack;
                b_take = input_b_stb && input_b_ack;
                z_take = output_z_stb && output_z_ack;
                if (a_take) n_a_hs++;
                if (b_take) n_b_hs++;
                if (output_z_stb && !output_z_ack) z_stall++;
                if (output_z_ack && dbg_res_count == 3'(DEPTH)) ack_when_full++;
                a_prev = input_a_stb;
            end
        end
    end

    // ---------------- stub double-precision int_to_float ----------------
    initial begin
        input_a_ack_dp = 0; input_b_ack_dp = 0; output_z_stb_dp = 0; output_z_dp = '0;
        got_a_dp = 0; a_take_dp = 0; z_take_dp = 0; a_val_dp = '0;
        forever begin
            @(negedge clock);
            if (!reset_n) begin
                input_a_ack_dp = 0; output_z_stb_dp = 0; output_z_dp = '0;
                got_a_dp = 0; a_take_dp = 0; z_take_dp = 0;
            end else begin
                if (a_take_dp) begin input_a_ack_dp = 0; got_a_dp = 1; end
                if (z_take_dp) begin output_z_stb_dp = 0; got_a_dp = 0; end
                if (input_a_stb_dp && !input_a_ack_dp && !got_a_dp) begin
                    input_a_ack_dp = 1;
                    a_val_dp = input_a_dp;
                end
                if (got_a_dp && !output_z_stb_dp) begin
                    output_z_stb_dp = 1;
                    output_z_dp = $realtobits(real'(a_val_dp));
                end
                #1;
                if (input_b_stb_dp) b_stb_dp_seen++;
                a_take_dp = input_a_stb_dp && input_a_ack_dp;
                z_take_dp = output_z_stb_dp && output_z_ack_dp;
            end
        end
    end

    // ---------------- result consumers / scoreboard ----------------
    initial begin
        out_ready = 0;
        forever begin
            @(negedge clock);
            if (rd_mode == 0) out_ready = 1;
            else if (rd_mode == 2) out_ready = 1'($urandom_range(0, 1));
            else out_ready = 0;
            #1;
            if (rd_mode == 4 && output_z_ack) begin
                out_ready = 1;
                rd_mode = 1;
            end
            if (reset_n && out_valid && out_ready) begin
                if (exp_q.size() == 0) check_val("spurious_out", 64'(out_valid), 64'd0);
                else check_val("out_z", 64'(out_z), 64'(exp_q.pop_front()));
                n_out++;
            end
        end
    end

    initial begin
        out_ready_dp = 0;
        forever begin
            @(negedge clock);
            out_ready_dp = (rd_mode_dp == 0);
            #1;
            if (reset_n && out_valid_dp && out_ready_dp) begin
                if (exp_q_dp.size() == 0) check_val("spurious_out_dp", 64'(out_valid_dp), 64'd0);
                else check_val("out_z_dp", out_z_dp, exp_q_dp.pop_front());
                n_out_dp++;
            end
        end
    end

    initial begin
        #500000;
        n_fail++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin
        reset_n = 0;
        in_valid = 0; in_a = '0; in_b = '0;
        in_valid_dp = 0; in_a_dp = '0; in_b_dp = '0;
        saw_backpressure = 0;
        repeat (3) tick();

        // reset values
        check_val("rst_state", 64'(dbg_state), 64'(S_RESET));
        check_val("rst_rst", 64'(rst), 64'd1);
        check_val("rst_in_ready", 64'(in_ready), 64'd0);
        check_val("rst_out_valid", 64'(out_valid), 64'd0);
        check_val("rst_out_z", 64'(out_z), 64'd0);
        check_val("rst_busy", 64'(busy), 64'd0);
        check_val("rst_strobes", 64'({input_a_stb, input_b_stb, output_z_ack}), 64'd0);
        check_val("rst_inputs", 64'({input_a, input_b}), 64'd0);

        @(negedge clock);
        reset_n = 1;
        #1;
        check_val("rel_rst_high", 64'(rst), 64'd1);
        check_val("rel_in_ready_low", 64'(in_ready), 64'd0);
        tick();
        check_val("rel_rst_low", 64'(rst), 64'd0);
        check_val("rel_in_ready_high", 64'(in_ready), 64'd1);
        check_val("rel_state", 64'(dbg_state), 64'(S_IDLE));

        // single op, immediate acks, latency walk
        a_dly = 0; b_dly = 0; z_lat = 0; rd_mode = 1;
        send32(32'h3F80_0000, 32'h4000_0000);
        #1;
        check_val("t1_op_count", 64'(dbg_op_count), 64'd1);
        check_val("t1_busy", 64'(busy), 64'd1);
        tick();
        check_val("t1_a_stb", 64'(input_a_stb), 64'd1);
        check_val("t1_b_stb", 64'(input_b_stb), 64'd1);
        check_val("t1_input_a", 64'(input_a), 64'h3F80_0000);
        check_val("t1_input_b", 64'(input_b), 64'h4000_0000);
        tick();
        check_val("t1_wait_state", 64'(dbg_state), 64'(S_WAIT_Z));
        check_val("t1_z_ack", 64'(output_z_ack), 64'd1);
        check_val("t1_out_valid_early", 64'(out_valid), 64'd0);
        tick();
        check_val("t1_out_valid", 64'(out_valid), 64'd1);
        check_val("t1_out_z", 64'(out_z), 64'h4040_0000);
        drain32("t1_drain");

        // burst of 6 with the user stalled
        a_dly = 0; b_dly = 0; z_lat = 2; rd_mode = 1;
        saw_backpressure = 0; z_stall = 0; base_out = n_out;
        for (int i = 0; i < 6; i++)
            send32(sp_of_int(int'($urandom_range(1, 1000))), sp_of_int(int'($urandom_range(1, 1000))));
        check_val("t2_in_ready_dropped", 64'(saw_backpressure), 64'd1);
        for (i_guard = 0; i_guard < 200 && !(dbg_res_count == 3'(DEPTH) && output_z_stb); i_guard++) tick();
        check_val("t2_res_full", 64'(dbg_res_count), 64'(DEPTH));
        repeat (3) tick();
        check_val("t2_z_ack_held", 64'(output_z_ack), 64'd0);
        check_val("t2_z_stb_held", 64'(output_z_stb), 64'd1);
        check_val("t2_stalled", 64'(z_stall >= 3), 64'd1);
        drain32("t2_drain");
        check_val("t2_result_count", 64'(n_out - base_out), 64'd6);

        // out-of-order delayed acks: B three cycles before A
        a_dly = 4; b_dly = 1; z_lat = 0;
        base_out = n_out; base_a = n_a_hs; base_b = n_b_hs;
        send32(sp_of_int(7), sp_of_int(9));
        repeat (3) tick();
        check_val("t3_a_stb_held", 64'(input_a_stb), 64'd1);
        check_val("t3_b_stb_done", 64'(input_b_stb), 64'd0);
        drain32("t3_drain");
        check_val("t3_a_hs", 64'(n_a_hs - base_a), 64'd1);
        check_val("t3_b_hs", 64'(n_b_hs - base_b), 64'd1);
        check_val("t3_results", 64'(n_out - base_out), 64'd1);

        // unary double-precision unit
        rd_mode_dp = 1;
        send64(5);
        for (i_guard = 0; i_guard < 100 && !out_valid_dp; i_guard++) tick();
        check_val("t4_out_valid", 64'(out_valid_dp), 64'd1);
        check_val("t4_out_z", out_z_dp, 64'h4014_0000_0000_0000);
        rd_mode_dp = 0;
        send64(1);
        send64(100);
        send64(12345);
        for (i_guard = 0; i_guard < 200 && !(exp_q_dp.size() == 0 && !busy_dp); i_guard++) tick();
        check_val("t4_drain", 64'(busy_dp), 64'd0);
        check_val("t4_no_b_stb", 64'(b_stb_dp_seen), 64'd0);

        // asynchronous reset in WAIT_Z with two ops queued
        a_dly = 0; b_dly = 0; z_lat = 20; rd_mode = 1;
        send32(sp_of_int(1), sp_of_int(2));
        send32(sp_of_int(3), sp_of_int(4));
        send32(sp_of_int(5), sp_of_int(6));
        for (i_guard = 0; i_guard < 100 && !(dbg_state == S_WAIT_Z && dbg_op_count == 3'd2); i_guard++) tick();
        check_val("t5_setup", 64'(dbg_op_count), 64'd2);
        #2;
        reset_n = 0;
        #1;
        check_val("t5_state", 64'(dbg_state), 64'(S_RESET));
        check_val("t5_rst", 64'(rst), 64'd1);
        check_val("t5_busy", 64'(busy), 64'd0);
        check_val("t5_in_ready", 64'(in_ready), 64'd0);
        check_val("t5_out", 64'({out_valid, out_z}), 64'd0);
        check_val("t5_strobes", 64'({input_a_stb, input_b_stb, output_z_ack}), 64'd0);
        check_val("t5_counts", 64'({dbg_op_count, dbg_res_count}), 64'd0);
        exp_q.delete();
        repeat (2) tick();
        @(negedge clock);
        reset_n = 1;
        z_lat = 0; rd_mode = 0; base_out = n_out;
        repeat (20) tick();
        check_val("t5_busy_after", 64'(busy), 64'd0);
        check_val("t5_out_valid_after", 64'(out_valid), 64'd0);
        check_val("t5_no_stale", 64'(n_out - base_out), 64'd0);

        // simultaneous result pop and push with two entries held
        rd_mode = 1; z_lat = 0;
        send32(sp_of_int(11), sp_of_int(22));
        send32(sp_of_int(33), sp_of_int(44));
        for (i_guard = 0; i_guard < 100 && !(dbg_res_count == 3'd2 && dbg_state == S_IDLE); i_guard++) tick();
        check_val("t6_two_held", 64'(dbg_res_count), 64'd2);
        z_lat = 3; rd_mode = 4;
        send32(sp_of_int(55), sp_of_int(66));
        for (i_guard = 0; i_guard < 100 && rd_mode != 1; i_guard++) tick();
        tick();
        check_val("t6_count_kept", 64'(dbg_res_count), 64'd2);
        check_val("t6_state_idle", 64'(dbg_state), 64'(S_IDLE));
        drain32("t6_drain");

        // random delays with random user backpressure
        rd_mode = 2;
        for (int i = 0; i < 8; i++) begin
            a_dly = int'($urandom_range(0, 3));
            b_dly = int'($urandom_range(0, 3));
            z_lat = int'($urandom_range(0, 3));
            send32(sp_of_int(int'($urandom_range(0, 5000))), sp_of_int(int'($urandom_range(0, 5000))));
        end
        drain32("t7_drain");

        check_val("end_exp_q_empty", 64'(exp_q.size()), 64'd0);
        check_val("end_exp_q_dp_empty", 64'(exp_q_dp.size()), 64'd0);
        check_val("end_ack_when_full", 64'(ack_when_full), 64'd0);
        check_val("end_b_restrobe", 64'(b_restrobe), 64'd0);
        check_val("end_a_drop", 64'(a_drop), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/dawson_stream_if.md
# dawson_stream_if

Parametrised, streaming successor to the single-shot Dawson "chips" bridge. The block accepts operand pairs over a valid/ready user interface, queues them in an operand FIFO, and drives them into one Dawson FPU unit using the chips strobe/ack protocol. Results are queued in a result FIFO with user backpressure. The block sits between datapath control and any Dawson unit: adder, multiplier, divider, or converter, in single or double precision.

## Interface
- WIDTH, 32: operand/result width in bits; only 32 and 64 are legal.
- DEPTH, 4: entries in each of the operand and result FIFOs; a power of 2, at least 2.
- NUM_OPERANDS, 2: operands per operation; 2 for binary units, 1 for unary units (int_to_float etc.).
- clock  in  1  block clock; also forwarded to the Dawson unit.
- reset_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  operand FIFO can accept.
- in_a  in  WIDTH  operand A.
- in_b  in  WIDTH  operand B; ignored when NUM_OPERANDS=1.
- out_valid  out  1  result FIFO non-empty.
- out_ready  in  1  user consumes result.
- out_z  out  WIDTH  result at FIFO head.
- busy  out  1  operation queued, in flight, or result pending.
- clk  out  1  equals clock.
- rst  out  1  Dawson unit synchronous reset.
- input_a, input_b  out  WIDTH  operands to the unit.
- input_a_stb, input_b_stb  out  1  operand strobes.
- input_a_ack, input_b_ack  in  1  operand acks.
- output_z  in  WIDTH  unit result.
- output_z_stb  in  1  result strobe.
- output_z_ack  out  1  result ack.

## Operation
- User input handshake: a transfer occurs on any edge with in_valid && in_ready. {in_a, in_b} is pushed into the operand FIFO.
- in_ready = !op_full && state != RESET.
- User output handshake: a transfer occurs on any edge with out_valid && out_ready, which pops the result FIFO.
- out_z = result head when out_valid, else 0.
- FSM states, transitions and outputs:
  - RESET: rst=1, then → IDLE unconditionally.
  - IDLE: if the operand FIFO is non-empty, pop its head into hold registers opa/opb, clear flags a_done/b_done, and go → TX.
  - TX: input_a_stb = !a_done; input_b_stb = !b_done && NUM_OPERANDS==2. input_a/input_b carry opa/opb while the matching strobe is high, else 0.
    - Each ack received while its strobe is high sets the matching done flag.
    - When both required acks have been seen (possibly on the same edge, or in any order), go → WAIT_Z.
    - With NUM_OPERANDS=1, b_done is treated as 1 from entry.
  - WAIT_Z: output_z_ack = output_z_stb && !res_full, combinationally. On an edge where ack && stb, output_z is pushed into the result FIFO and the FSM goes → IDLE.
- Backpressure: a full result FIFO holds output_z_ack low. The Dawson unit keeps its strobe asserted. No result is lost or duplicated.
- A result pop and an output_z push in the same cycle are both legal when the FIFO is not full. A full FIFO does not pass results through: no ack is given even if out_ready is high in that cycle.
- Exactly one operation is in flight at a time. Results are returned in input order.
- busy = (state != IDLE && state != RESET) || !op_empty || !res_empty.
- Occupancy counters are $clog2(DEPTH)+1 bits wide. Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH.

## Timing
- While reset_n is low, the following hold:
  - state=RESET and rst=1.
  - FIFOs are empty and pointers are 0.
  - in_ready=0, out_valid=0, out_z=0, busy=0.
  - All strobes, output_z_ack, input_a and input_b are 0.
- First edge after reset_n rises: FSM goes RESET→IDLE. rst falls and in_ready rises.
- Latency, with an empty FIFO, an idle FSM and immediate acks:
  - Input accepted at edge e.
  - IDLE pops at edge e+1.
  - Strobes are high in the cycle after e+1.
  - A result acked at edge r gives out_valid=1 in the cycle after r.
- Minimum issue interval is 3 cycles plus unit latency (IDLE, TX, WAIT_Z).
- If reset_n is asserted mid-operation, all state clears immediately. The in-flight operation and queued data are discarded. rst to the unit stays high until the RESET state exits.
- Simultaneous push and pop on the operand FIFO when it is neither empty nor full leaves the count unchanged.

## Structure
- Package chips_if_pkg holds:
  - the state_t enum {RESET, IDLE, TX, WAIT_Z};
  - the legal WIDTH constants WIDTH_SP=32 and WIDTH_DP=64.
- Sub-module chips_fifo is parametrised by data width and DEPTH. It has push/pop/full/empty/count and combinational head read.
  - It is instantiated twice: operands at width 2*WIDTH, results at width WIDTH.

## Test plan
- Reset, then one op, with WIDTH=32, NUM_OPERANDS=2 and a stub adder that acks immediately: a=0x3F800000, b=0x40000000 → out_z=0x40400000 with out_valid. rst is high for exactly one cycle after reset_n rises.
- Burst of 6 ops while out_ready=0, DEPTH=4: the result FIFO fills to 4 and output_z_ack stays low while output_z_stb is high. in_ready drops once the operand FIFO is full. Draining returns all 6 results in order with no drops.
- Acks delayed and out of order, with b acked 3 cycles before a: the FSM holds input_a_stb until a's ack and never re-strobes b. Exactly one result is produced.
- NUM_OPERANDS=1, WIDTH=64, stub int_to_float: input_b_stb is never asserted. in_a=5 → out_z=0x4014000000000000.
- reset_n asserted during WAIT_Z with 2 ops queued: outputs take their reset values asynchronously. After release busy=0, out_valid=0, and no stale result appears.
- Simultaneous result pop and output_z push with 2 entries occupied: the count stays at 2 and order is preserved.
